// File: rtl/memory_responder.sv
// Word-organised memory answering core requests over valid/ready with LATENCY wait states.
// Optional address checking (misaligned / out-of-range -> rsp_err) is enabled by defining MEMRESP_CHECK_EN.
module memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [3:0]      count_r;
    logic            we_r;
    logic [AW-1:0]   idx_r;
    logic [31:0]     wdata_r;
    logic [3:0]      wstrb_r;
    logic            err_r;
    logic            err_s;
    logic [31:0]     mem_r [DEPTH_WORDS];

    assign req_ready = (state_r == IDLE) && !reset;

`ifdef MEMRESP_CHECK_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    // Flag misaligned and out-of-range requests at acceptance time
    always_comb begin
        err_s = 1'b0;
        if (req_addr[1:0] != 2'b00) begin
            err_s = 1'b1;
        end else if ({1'b0, req_addr} >= ADDR_LIMIT) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end
`else
    // Byte offset and upper address bits are don't-care; the word index wraps
    logic unused_addr_s;
    assign unused_addr_s = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign err_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (LAT4 == 4'd0) begin
                        state_next_s = ACCESS;
                    end else begin
                        state_next_s = WAIT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (count_r == 4'd1) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = WAIT;
                end
            end
            ACCESS: state_next_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Request latch, wait counter and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= 4'd0;
            we_r      <= 1'b0;
            idx_r     <= '0;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'h0;
            err_r     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        count_r <= LAT4;
                        we_r    <= req_we;
                        idx_r   <= req_addr[AW+1:2];
                        wdata_r <= req_wdata;
                        wstrb_r <= req_wstrb;
                        err_r   <= err_s;
                    end
                end
                WAIT: count_r <= count_r - 4'd1;
                ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_r;
                    rsp_rdata <= (we_r || err_r) ? 32'h0000_0000 : mem_r[idx_r];
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane write commit; the array itself is deliberately not reset
    always_ff @(posedge clk) begin
        if ((state_r == ACCESS) && we_r && !err_r && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: driver pushes expected responses, a negedge monitor checks them.
module tb_memory_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_req_we = 1'b0;
    logic [31:0] z_req_addr = 32'h0;
    logic [31:0] z_req_wdata = 32'h0;
    logic [3:0]  z_req_wstrb = 4'h0;
    logic        z_rsp_valid;
    logic        z_rsp_ready = 1'b1;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

    memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_lat0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency of each new response and content of each consumed response
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rsp_valid && !prev_valid)
                check("rsp_latency", 32'(cyc - acc_edge), 32'(LAT + 1));
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got response %h, expected none", rsp_rdata);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
        prev_valid <= rsp_valid;
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic push);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_ready_timeout: got 0, expected 1 within 100 cycles");
        end else begin
            req_we    = we;
            req_addr  = addr;
            req_wdata = wdata;
            req_wstrb = wstrb;
            req_valid = 1'b1;
            acc_edge  = cyc + 1;
            if (push) sb_q.push_back('{rdata: exp_rdata, err: exp_err});
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_rsp_valid();
        int t = 0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rsp_valid_arrives", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        logic [31:0] exp13;
        logic [31:0] exp_top;
        logic        err_bad;
`ifdef MEMRESP_CHECK_EN
        exp13 = 32'h0000_0000; exp_top = 32'h0000_0000; err_bad = 1'b1;
`else
        exp13 = 32'hDEAD_BEEF; exp_top = 32'hCAFE_F00D; err_bad = 1'b0;
`endif
        // Reset state while reset is held
        #12;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", 32'(req_ready), 32'd1);

        // Write then read
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // Byte strobes, including an all-zero strobe
        issue(1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1);
        issue(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1);

        // Address handling
        issue(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h13, 32'h0, 4'h0, exp13, err_bad, 1'b1);
        issue(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, exp_top, err_bad, 1'b1);
        drain();

        // Back-pressure
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_rsp_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_req_ready", 32'(req_ready), 32'd1);
        check("bp_rsp_valid_clear", 32'(rsp_valid), 32'd0);
        drain();

        // Reset during WAIT discards the write
        issue(1'b1, 32'h30, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0, 1'b1);
        drain();
        issue(1'b1, 32'h30, 32'h0000_0000, 4'hF, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue(1'b0, 32'h30, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0, 1'b1);
        drain();

        // Asynchronous reset with a response in flight
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        wait_rsp_valid();
        check("inflight_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        #2 reset = 1'b1;
        #1;
        check("async_req_ready", 32'(req_ready), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rsp_err", 32'(rsp_err), 32'd0);
        check("async_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_req_ready", 32'(req_ready), 32'd1);

        // LATENCY=0 instance: response one edge after acceptance
        @(negedge clk);
        check("lat0_req_ready", 32'(z_req_ready), 32'd1);
        z_req_we = 1'b1; z_req_addr = 32'h40; z_req_wdata = 32'h1234_5678; z_req_wstrb = 4'hF;
        z_req_valid = 1'b1;
        @(negedge clk);
        z_req_valid = 1'b0;
        check("lat0_rsp_not_yet", 32'(z_rsp_valid), 32'd0);
        @(negedge clk);
        check("lat0_wr_rsp_valid", 32'(z_rsp_valid), 32'd1);
        check("lat0_wr_rsp_rdata", z_rsp_rdata, 32'h0);
        @(negedge clk);
        check("lat0_rsp_one_cycle", 32'(z_rsp_valid), 32'd0);
        check("lat0_idle_again", 32'(z_req_ready), 32'd1);
        z_req_we = 1'b0;
        z_req_valid = 1'b1;
        @(negedge clk);
        z_req_valid = 1'b0;
        @(negedge clk);
        check("lat0_rd_rsp_valid", 32'(z_rsp_valid), 32'd1);
        check("lat0_rd_rsp_rdata", z_rsp_rdata, 32'h1234_5678);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Word-organised data/instruction memory that answers the multicycle RISC-V core's memory accesses through a valid/ready request/response handshake with a programmable number of wait states. It accepts one request at a time, holds it for `LATENCY` cycles, commits writes with byte strobes or returns read data, and then presents a response until the core takes it. It sits between the core's address multiplexer / `RD2` write-data path and the instruction-register and `ReadData` consumers. It replaces the zero-latency combinational memory model.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: wait-state cycles between acceptance and response; range 0–15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  responder can accept; combinational, `(state==IDLE) && !reset`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte-lane enables; bit i enables `wdata[8i+7:8i]`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  core consumes the response.
- `rsp_rdata`  out  32  read data; 0 for write responses and for errored requests.
- `rsp_err`  out  1  request rejected (see Configuration).

## Operation
- FSM states:
  - **IDLE**: `req_ready`=1. On `req_valid`, latch `we`/`addr`/`wdata`/`wstrb` and go to WAIT, with counter = `LATENCY`. If `LATENCY`==0, go straight to ACCESS.
  - **WAIT**: decrement the counter each cycle. Go to ACCESS on the cycle the counter is 1.
  - **ACCESS**: one cycle.
    - Write: update the enabled byte lanes of `mem[addr[log2(DEPTH)+1:2]]`.
    - Read: register the word into `rsp_rdata`.
    - Set `rsp_valid`, then go to RESP.
  - **RESP**: hold `rsp_valid`/`rsp_rdata`/`rsp_err` stable until `rsp_ready`=1. On that edge, clear `rsp_valid` and `rsp_err` and return to IDLE.
- Only one outstanding request. `req_*` inputs are ignored outside IDLE.
- `req_wstrb`==0 on a write is legal: no bytes change, and a normal response is returned.
- Reads capture memory contents as of the ACCESS edge.
- Memory array is not cleared by `reset`.
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req_ready`=0 while `reset` is high, state=IDLE, counter=0.
- Reset mid-operation: the latched request is discarded. A write not yet in ACCESS is never committed. A response in flight is dropped.

## Timing
- Request accepted at edge N (`req_valid && req_ready`).
- Write commit and read capture happen at edge N+`LATENCY`+1.
- `rsp_valid` is high from edge N+`LATENCY`+1 onward.
- Minimum request-to-request spacing is `LATENCY`+3 edges: the response is consumed the cycle it appears, and IDLE is re-entered one cycle later.
- `rsp_ready` held high continuously: `rsp_valid` stays high for exactly one cycle.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.

## Configuration
- `MEMRESP_CHECK_EN` defined:
  - Requests with `req_addr[1:0]`≠0 set `rsp_err`=1.
  - Requests with `req_addr` ≥ 4·`DEPTH_WORDS` set `rsp_err`=1.
  - Errored writes modify nothing; errored reads return `rsp_rdata`=0.
  - Errored requests keep the same latency and handshake as normal requests.
- Not defined:
  - `req_addr[1:0]` is ignored.
  - Word index wraps modulo `DEPTH_WORDS`.
  - `rsp_err` is tied to 0.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle → `req_ready`, `rsp_valid`, `rsp_err` and `rsp_rdata` are 0 immediately. Release `reset` → `req_ready`=1 after the next edge.
- Write then read, `LATENCY`=2, `rsp_ready`=1:
  - Write `0xDEADBEEF` to `0x10`, `wstrb`=`4'hF` → `rsp_valid` 3 edges after acceptance, for one cycle.
  - Read `0x10` → `rsp_rdata`=`0xDEADBEEF`.
- Byte strobes: write `0x11223344` to `0x20`, then write `0xAABBCCDD` with `wstrb`=`4'b0101` → read of `0x20` returns `0x11BB33DD`.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises → `rsp_valid` and `rsp_rdata` stay stable and `req_ready` stays 0. Raise `rsp_ready` → IDLE next cycle.
- Reset mid-write: accept a write of `0x0` to `0x30` (previously `0x55AA55AA`) and assert `reset` during WAIT → subsequent read of `0x30` returns `0x55AA55AA`.
- Address handling:
  - `MEMRESP_CHECK_EN` defined: read `0x13` → `rsp_err`=1, `rsp_rdata`=0. Read `4·DEPTH_WORDS` → `rsp_err`=1.
  - Not defined: read `0x13` returns the word at `0x10`. Read `4·DEPTH_WORDS` returns the word at `0x0`.
- `LATENCY`=0 build: write at edge N → `rsp_valid` high from edge N+1.
